// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg: shared encodings and defaults for the fetch sequencer. Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int DEFAULT_ADDR_W  = 8;
  localparam int DEFAULT_INSTR_W = 24;

  localparam logic [1:0] BR_JUMP = 2'b00;
  localparam logic [1:0] BR_CALL = 2'b01;
  localparam logic [1:0] BR_RET  = 2'b10;
  localparam logic [1:0] BR_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ret_stack: DEPTH x WIDTH LIFO; push when full / pop when empty are ignored.
// Rev 1.0
// ---------------------------------------------------------------------------
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      sp;
  logic [AW-1:0]    top_idx;

  assign top_idx = AW'(sp - (AW+1)'(1));
  assign top     = mem[top_idx];
  assign full    = (sp == (AW+1)'(DEPTH));
  assign empty   = (sp == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (AW+1)'(1);
    end
  end

  // Storage needs no reset: sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_ctrl: pc/FSM, 1-cycle ROM read tracking, 2-entry output FIFO, RAS.
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int INSTR_W   = DEFAULT_INSTR_W,
  parameter int LAST_ADDR = 254,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_valid,
  input  logic [1:0]         br_op,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               run,
  output logic               halted,
  output logic               ras_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t              state;
  logic [ADDR_W-1:0]   pc, pend_pc;
  logic                pend;
  logic                slot0_valid, slot1_valid;
  logic [INSTR_W-1:0]  slot0_data, slot1_data;
  logic [ADDR_W-1:0]   slot0_pc, slot1_pc;

  logic                n0_valid, n1_valid;
  logic [INSTR_W-1:0]  n0_data, n1_data;
  logic [ADDR_W-1:0]   n0_pc, n1_pc;

  logic                transfer, redirect, issue;
  logic [1:0]          occ_next;
  logic                ras_push, ras_pop, ras_full, ras_empty;
  logic [ADDR_W-1:0]   ras_top, ret_addr;

  assign transfer = slot0_valid & instr_ready;
  assign redirect = br_valid & transfer;
  // Occupancy once this cycle's pop and returning read have both settled.
  assign occ_next = 2'(slot0_valid) + 2'(slot1_valid) + 2'(pend) - 2'(transfer);
  assign issue    = (state == ST_RUN) && !redirect && (occ_next < 2'd2);

  assign rom_addr    = pc;
  assign instr       = slot0_data;
  assign instr_pc    = slot0_pc;
  assign instr_valid = slot0_valid;
  assign halted      = (state != ST_RUN);
  assign ret_addr    = slot0_pc + ADDR_W'(1);

  assign ras_push = redirect && (br_op == BR_CALL) && !ras_full;
  assign ras_pop  = redirect && (br_op == BR_RET) && !ras_empty;

  ret_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (ret_addr),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_comb begin
    n0_valid = slot0_valid;
    n0_data  = slot0_data;
    n0_pc    = slot0_pc;
    n1_valid = slot1_valid;
    n1_data  = slot1_data;
    n1_pc    = slot1_pc;
    if (transfer) begin
      n0_valid = slot1_valid;
      n0_data  = slot1_data;
      n0_pc    = slot1_pc;
      n1_valid = 1'b0;
    end
    if (pend) begin
      if (!n0_valid) begin
        n0_valid = 1'b1;
        n0_data  = rom_data;
        n0_pc    = pend_pc;
      end else begin
        n1_valid = 1'b1;
        n1_data  = rom_data;
        n1_pc    = pend_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HALT;
      pc          <= '0;
      pend        <= 1'b0;
      pend_pc     <= '0;
      slot0_valid <= 1'b0;
      slot1_valid <= 1'b0;
      slot0_data  <= '0;
      slot1_data  <= '0;
      slot0_pc    <= '0;
      slot1_pc    <= '0;
      ras_err     <= 1'b0;
    end else if (redirect) begin
      // Flush everything, including the read still in flight.
      slot0_valid <= 1'b0;
      slot1_valid <= 1'b0;
      pend        <= 1'b0;
      unique case (br_op)
        BR_JUMP: begin
          pc    <= br_target;
          state <= ST_RUN;
        end
        BR_CALL: begin
          pc    <= br_target;
          state <= ST_RUN;
          if (ras_full) ras_err <= 1'b1;
        end
        BR_RET: begin
          pc    <= ras_empty ? '0 : ras_top;
          state <= ST_RUN;
          if (ras_empty) ras_err <= 1'b1;
        end
        BR_HALT: begin
          pc    <= ret_addr;
          state <= ST_HALT;
        end
      endcase
    end else begin
      slot0_valid <= n0_valid;
      slot0_data  <= n0_data;
      slot0_pc    <= n0_pc;
      slot1_valid <= n1_valid;
      slot1_data  <= n1_data;
      slot1_pc    <= n1_pc;
      pend        <= issue;
      if (issue) pend_pc <= pc;
      if (state == ST_HALT && run) state <= ST_RUN;
      if (issue) begin
        if (pc >= LAST) state <= ST_DONE;
        else            pc    <= pc + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_ctrl: directed and random program-flow stimulus against a model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int LAST = 254;
  localparam int M_RUN = 0, M_HALT = 1, M_END = 2;

  logic        clk = 1'b0;
  logic        rst, instr_ready, br_valid, run;
  logic [1:0]  br_op;
  logic [7:0]  br_target, rom_addr, instr_pc;
  logic [23:0] rom_data, instr;
  logic        instr_valid, halted, ras_err;
  logic [23:0] rom [256];

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_valid(br_valid), .br_op(br_op),
    .br_target(br_target), .run(run), .halted(halted), .ras_err(ras_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Architectural model: next pc to be delivered, mode, return stack, error.
  int mode, exp_pc, lat, stall_cnt, halt_wait, end_cnt, ptr, t_end;
  bit m_err;
  int stk[$];

  int         t_pc [17] = '{3, 'h23, 5, 'h42, 10, 12, 'h50, 'h60, 'h70, 'h80,
                            'h90, 'h71, 'h61, 'h51, 13, 2, 4};
  logic [1:0] t_op [17] = '{BR_JUMP, BR_JUMP, BR_CALL, BR_RET, BR_HALT, BR_CALL,
                            BR_CALL, BR_CALL, BR_CALL, BR_CALL, BR_RET, BR_RET,
                            BR_RET, BR_RET, BR_RET, BR_RET, BR_JUMP};
  logic [7:0] t_tg [17] = '{8'h20, 8'h05, 8'h40, 8'h00, 8'h00, 8'h50, 8'h60, 8'h70,
                            8'h80, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd250};

  task automatic model_reset();
    mode = M_HALT; exp_pc = 0; lat = 100; m_err = 0; end_cnt = 0; halt_wait = 0;
    stk.delete();
  endtask

  task automatic reset_check();
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 1);
    check("rst_ras_err", ras_err, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
  endtask

  task automatic do_reset();
    rst = 1; instr_ready = 0; br_valid = 0; br_op = 0; br_target = 0; run = 0;
    @(negedge clk);
    reset_check();
    rst = 0;
    model_reset();
  endtask

  task automatic check_cycle();
    if (lat < 100) lat++;
    check("ras_err", ras_err, m_err);
    if (mode != M_RUN) begin
      check("halted", halted, 1);
      check("idle_no_valid", instr_valid, 0);
    end else begin
      if (lat == 1) check("run_halted", halted, 0);
      if (lat == 1 || lat == 2) check("early_valid", instr_valid, 0);
      if (lat == 3) check("first_valid", instr_valid, 1);
      if (instr_valid) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr", instr, rom[exp_pc]);
      end
    end
  endtask

  task automatic apply(input bit rdy, input bit bv, input logic [1:0] op,
                       input logic [7:0] tg, input bit rn);
    instr_ready = rdy; br_valid = bv; br_op = op; br_target = tg; run = rn;
    if (instr_valid && rdy && mode == M_RUN) begin
      if (bv) begin
        lat = 0;
        case (op)
          BR_JUMP: exp_pc = tg;
          BR_CALL: begin
            if (stk.size() < 4) stk.push_back((exp_pc + 1) % 256);
            else m_err = 1;
            exp_pc = tg;
          end
          BR_RET: begin
            if (stk.size() > 0) exp_pc = stk.pop_back();
            else begin exp_pc = 0; m_err = 1; end
          end
          default: begin exp_pc = (exp_pc + 1) % 256; mode = M_HALT; lat = 100; end
        endcase
      end else if (exp_pc >= LAST) begin
        mode = M_END;
      end else begin
        exp_pc++;
      end
    end else if (mode == M_HALT && rn) begin
      mode = M_RUN; lat = 0;
    end
  endtask

  task automatic dir_step();
    bit rdy, bv, rn;
    logic [1:0] op;
    logic [7:0] tg;
    rdy = 1; bv = 0; rn = 0; op = 0; tg = 0;
    if (instr_valid && mode == M_RUN && exp_pc == 'h22 && stall_cnt < 5) begin
      rdy = 0; stall_cnt++;
    end
    if (instr_valid && rdy && mode == M_RUN && ptr < t_end && exp_pc == t_pc[ptr]) begin
      bv = 1; op = t_op[ptr]; tg = t_tg[ptr]; ptr++;
    end
    if (mode == M_HALT) begin
      halt_wait++;
      if (halt_wait >= 3) begin rn = 1; halt_wait = 0; end
    end
    if (mode == M_END) rn = 1;
    apply(rdy, bv, op, tg, rn);
  endtask

  task automatic rnd_step();
    bit rdy, bv, rn;
    logic [1:0] op;
    logic [7:0] tg;
    rdy = ($urandom_range(0, 3) != 0);
    bv  = ($urandom_range(0, 9) == 0);
    op  = 2'($urandom_range(0, 3));
    tg  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 255));
    rn  = (mode == M_HALT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
    apply(rdy, bv, op, tg, rn);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
    stall_cnt = 0; ptr = 0; t_end = 15;
    rst = 1; instr_ready = 0; br_valid = 0; br_op = 0; br_target = 0; run = 0;
    repeat (2) @(negedge clk);
    reset_check();
    rst = 0;
    model_reset();

    // jump / stall / call-ret / halt-resume / nested-call overflow
    for (int i = 0; i < 200; i++) begin
      dir_step(); @(negedge clk); check_cycle();
    end
    check("dir1_progress", ptr, 15);
    check("dir1_stall", stall_cnt, 5);

    // ret on empty stack, then run off the end of ROM with run pulses ignored
    do_reset();
    t_end = 17;
    for (int i = 0; i < 60; i++) begin
      dir_step(); @(negedge clk); check_cycle();
    end
    check("dir2_progress", ptr, 17);
    check("dir2_end", mode, M_END);

    // reset while a ROM read is in flight
    do_reset();
    apply(1, 0, 0, 0, 1); @(negedge clk); check_cycle();
    apply(1, 0, 0, 0, 0); @(negedge clk); check_cycle();
    apply(1, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    reset_check();
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 0); @(negedge clk); check_cycle();
    end

    // random program flow
    for (int i = 0; i < 4000; i++) begin
      if (mode == M_END && ++end_cnt > 6) begin
        do_reset();
      end else begin
        rnd_step(); @(negedge clk); check_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
